// File: rtl/run_controller.sv
// run_controller: sequences a core through reset, run, pipeline drain and
// completion. It counts run cycles and retired instructions, stops on a
// programmable run of halt opcodes, and aborts a run that never halts.
module run_controller #(
  parameter int unsigned     OP_W           = 6,
  parameter logic [OP_W-1:0] HALT_OP        = '1,
  parameter int unsigned     HALT_MATCH     = 1,
  parameter int unsigned     RST_CYCLES     = 2,
  parameter int unsigned     DRAIN_CYCLES   = 3,
  parameter int unsigned     TIMEOUT_CYCLES = 100000,
  parameter int unsigned     CNT_W          = 32
) (
  input  logic             sysclk,
  input  logic             cpu_resetn,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             op_valid,
  output logic             core_resetn,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CRST    = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  // The timeout counter must be able to hold TIMEOUT_CYCLES itself, because
  // it still increments on the cycle that leaves RUN.
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0]      DR_LAST  = (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);
  localparam logic [3:0]      HM_LAST  = 4'(HALT_MATCH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_rst_cnt;
  logic [7:0]        r_dr_cnt;
  logic [3:0]        r_hm_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_instr;
  logic [CNT_W-1:0]  w_cyc_inc;
  logic [CNT_W-1:0]  w_instr_inc;
  logic              w_is_halt;
  logic              w_start_ok;
  logic              r_core_resetn;
  logic              r_running;
  logic              r_done;
  logic              r_timeout;

  // State register.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) r_state <= IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic; a halt completing on the timeout cycle takes priority.
  always_comb begin
    w_next      = r_state;
    w_is_halt   = op_valid && (op == HALT_OP);
    w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == TIMEOUT));
    w_cyc_inc   = (r_cyc == '1) ? r_cyc : r_cyc + CNT_W'(1);
    w_instr_inc = (r_instr == '1) ? r_instr : r_instr + CNT_W'(1);
    case (r_state)
      IDLE, DONE, TIMEOUT: if (start) w_next = CRST;
      CRST:                if (r_rst_cnt == RST_LAST) w_next = RUN;
      RUN: begin
        if (w_is_halt && (r_hm_cnt == HM_LAST))
          w_next = (DRAIN_CYCLES > 0) ? DRAIN : DONE;
        else if (r_to_cnt == TO_LAST)
          w_next = TIMEOUT;
      end
      DRAIN:               if (r_dr_cnt == DR_LAST) w_next = DONE;
      default:             w_next = IDLE;
    endcase
  end

  // Run counters: cleared by an accepted start, advanced by the current state.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_rst_cnt <= '0;
      r_dr_cnt  <= '0;
      r_hm_cnt  <= '0;
      r_to_cnt  <= '0;
      r_cyc     <= '0;
      r_instr   <= '0;
    end else if (w_start_ok) begin
      r_rst_cnt <= '0;
      r_dr_cnt  <= '0;
      r_hm_cnt  <= '0;
      r_to_cnt  <= '0;
      r_cyc     <= '0;
      r_instr   <= '0;
    end else begin
      case (r_state)
        CRST: r_rst_cnt <= r_rst_cnt + 8'd1;
        RUN: begin
          r_cyc    <= w_cyc_inc;
          r_to_cnt <= r_to_cnt + TO_W'(1);
          // Bubbles leave the halt match untouched; a real non-halt op restarts it.
          if (op_valid) begin
            r_instr  <= w_instr_inc;
            r_hm_cnt <= w_is_halt ? r_hm_cnt + 4'd1 : 4'd0;
          end
        end
        DRAIN: begin
          r_cyc    <= w_cyc_inc;
          r_dr_cnt <= r_dr_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs registered from the next state so they track the FSM edge.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_core_resetn <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_core_resetn <= !((w_next == IDLE) || (w_next == CRST));
      r_running     <= (w_next == RUN) || (w_next == DRAIN);
      r_done        <= (w_next == DONE);
      r_timeout     <= (w_next == TIMEOUT);
    end
  end

  assign core_resetn = r_core_resetn;
  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cyc;
  assign instr_count = r_instr;
  assign o_state     = r_state;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: five instances with different parameter sets,
// directed stimulus, and a completion scoreboard fed by the stimulus.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  start_i;
  logic [4:0]  opv_i;
  logic [5:0]  op_i [5];
  wire  [4:0]  crn, run_w, done_w, to_w;
  wire  [31:0] cc0, cc1, cc2, cc3, ic0, ic1, ic2, ic3;
  wire  [3:0]  cc4, ic4;
  wire  [2:0]  st0, st1, st2, st3, st4;

  int checks   = 0;
  int failures = 0;
  logic [68:0] exp_q[$];
  logic [4:0]  prev_ev = 5'b0;

  // Clock.
  always #5 clk = ~clk;

  run_controller u0 (
    .sysclk(clk), .cpu_resetn(rst_n), .start(start_i[0]), .op(op_i[0]), .op_valid(opv_i[0]),
    .core_resetn(crn[0]), .running(run_w[0]), .done(done_w[0]), .timeout(to_w[0]),
    .cycle_count(cc0), .instr_count(ic0), .o_state(st0));
  run_controller #(.HALT_MATCH(2)) u1 (
    .sysclk(clk), .cpu_resetn(rst_n), .start(start_i[1]), .op(op_i[1]), .op_valid(opv_i[1]),
    .core_resetn(crn[1]), .running(run_w[1]), .done(done_w[1]), .timeout(to_w[1]),
    .cycle_count(cc1), .instr_count(ic1), .o_state(st1));
  run_controller #(.TIMEOUT_CYCLES(20)) u2 (
    .sysclk(clk), .cpu_resetn(rst_n), .start(start_i[2]), .op(op_i[2]), .op_valid(opv_i[2]),
    .core_resetn(crn[2]), .running(run_w[2]), .done(done_w[2]), .timeout(to_w[2]),
    .cycle_count(cc2), .instr_count(ic2), .o_state(st2));
  run_controller #(.DRAIN_CYCLES(0)) u3 (
    .sysclk(clk), .cpu_resetn(rst_n), .start(start_i[3]), .op(op_i[3]), .op_valid(opv_i[3]),
    .core_resetn(crn[3]), .running(run_w[3]), .done(done_w[3]), .timeout(to_w[3]),
    .cycle_count(cc3), .instr_count(ic3), .o_state(st3));
  run_controller #(.CNT_W(4)) u4 (
    .sysclk(clk), .cpu_resetn(rst_n), .start(start_i[4]), .op(op_i[4]), .op_valid(opv_i[4]),
    .core_resetn(crn[4]), .running(run_w[4]), .done(done_w[4]), .timeout(to_w[4]),
    .cycle_count(cc4), .instr_count(ic4), .o_state(st4));

  function automatic logic [31:0] get_cc(int k);
    case (k)
      0: return cc0;
      1: return cc1;
      2: return cc2;
      3: return cc3;
      default: return {28'd0, cc4};
    endcase
  endfunction

  function automatic logic [31:0] get_ic(int k);
    case (k)
      0: return ic0;
      1: return ic1;
      2: return ic2;
      3: return ic3;
      default: return {28'd0, ic4};
    endcase
  endfunction

  function automatic logic [2:0] get_st(int k);
    case (k)
      0: return st0;
      1: return st1;
      2: return st2;
      3: return st3;
      default: return st4;
    endcase
  endfunction

  function automatic logic [68:0] rec(int k, logic d, logic t, logic [31:0] c, logic [31:0] i);
    return {3'(k), d, t, c, i};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic pulse_start(int k);
    start_i[k] = 1'b1;
    @(negedge clk);
    start_i[k] = 1'b0;
  endtask

  task automatic send(int k, logic v, logic [5:0] o);
    opv_i[k] = v;
    op_i[k]  = o;
    @(negedge clk);
  endtask

  task automatic wait_core_up(int k, string nm);
    int n = 0;
    while (crn[k] == 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 64'(n), 64'd2);
  endtask

  task automatic count_running(int k, string nm, int exp);
    int n = 0;
    while (run_w[k] == 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 64'(n), 64'(exp));
  endtask

  task automatic wait_end(int k, string nm);
    int n = 0;
    while (!(done_w[k] || to_w[k]) && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 64'(done_w[k] || to_w[k]), 64'd1);
  endtask

  // Scoreboard monitor: on every rising done/timeout, pop and compare.
  always @(negedge clk) begin
    logic [68:0] e;
    logic [68:0] a;
    for (int k = 0; k < 5; k++) begin
      if ((done_w[k] || to_w[k]) && !prev_ev[k]) begin
        checks++;
        a = rec(k, done_w[k], to_w[k], get_cc(k), get_ic(k));
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL completion: unexpected event %0h, nothing expected", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL completion: got %0h expected %0h", a, e);
          end
        end
      end
      prev_ev[k] <= done_w[k] || to_w[k];
    end
  end

  initial begin
    rst_n   = 1'b0;
    start_i = '0;
    opv_i   = '0;
    for (int k = 0; k < 5; k++) op_i[k] = '0;
    repeat (2) @(negedge clk);

    // Reset state on all instances.
    for (int k = 0; k < 5; k++) begin
      chk("reset_flags", 64'({crn[k], run_w[k], done_w[k], to_w[k], get_st(k)}), 64'd0);
      chk("reset_counts", {get_cc(k), get_ic(k)}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_core_held", 64'(crn[0]), 64'd0);

    // HALT_MATCH=2: broken match does not stop; a bubble keeps the match.
    pulse_start(1);
    wait_core_up(1, "hm_crst_len");
    exp_q.push_back(rec(1, 1'b1, 1'b0, 32'd10, 32'd6));
    send(1, 1'b1, 6'h3F);
    send(1, 1'b1, 6'h01);
    send(1, 1'b1, 6'h3F);
    chk("hm_no_stop", 64'({run_w[1], done_w[1], get_st(1)}), 64'({1'b1, 1'b0, 3'd2}));
    send(1, 1'b1, 6'h02);
    send(1, 1'b1, 6'h3F);
    send(1, 1'b0, 6'h3F);
    chk("hm_bubble_hold", 64'(run_w[1]), 64'd1);
    send(1, 1'b1, 6'h3F);
    opv_i[1] = 1'b0;
    chk("hm_stop_drain", 64'(get_st(1)), 64'd3);
    wait_end(1, "hm_end");

    // TIMEOUT_CYCLES=20: no halt aborts after 20 RUN cycles.
    pulse_start(2);
    wait_core_up(2, "to_crst_len");
    exp_q.push_back(rec(2, 1'b0, 1'b1, 32'd20, 32'd20));
    for (int i = 0; i < 20; i++) send(2, 1'b1, 6'(i));
    opv_i[2] = 1'b0;
    chk("to_flags", 64'({to_w[2], done_w[2], run_w[2]}), 64'({1'b1, 1'b0, 1'b0}));
    // Halt on RUN cycle 20 beats the timeout.
    pulse_start(2);
    wait_core_up(2, "to2_crst_len");
    exp_q.push_back(rec(2, 1'b1, 1'b0, 32'd23, 32'd20));
    for (int i = 0; i < 19; i++) send(2, 1'b1, 6'h10);
    send(2, 1'b1, 6'h3F);
    opv_i[2] = 1'b0;
    chk("to_halt_wins", 64'({to_w[2], run_w[2], get_st(2)}), 64'({1'b0, 1'b1, 3'd3}));
    wait_end(2, "to2_end");

    // DRAIN_CYCLES=0: done on the edge that samples the halt.
    pulse_start(3);
    wait_core_up(3, "dr0_crst_len");
    exp_q.push_back(rec(3, 1'b1, 1'b0, 32'd3, 32'd3));
    send(3, 1'b1, 6'h05);
    send(3, 1'b1, 6'h06);
    send(3, 1'b1, 6'h3F);
    opv_i[3] = 1'b0;
    chk("dr0_done_now", 64'({done_w[3], run_w[3]}), 64'({1'b1, 1'b0}));

    // CNT_W=4: counters saturate.
    pulse_start(4);
    wait_core_up(4, "sat_crst_len");
    exp_q.push_back(rec(4, 1'b1, 1'b0, 32'hF, 32'hF));
    for (int i = 0; i < 20; i++) send(4, 1'b1, 6'h11);
    send(4, 1'b1, 6'h3F);
    opv_i[4] = 1'b0;
    wait_end(4, "sat_end");

    // Defaults: 7 ops plus halt, 3 drain cycles.
    pulse_start(0);
    wait_core_up(0, "def_crst_len");
    exp_q.push_back(rec(0, 1'b1, 1'b0, 32'd11, 32'd8));
    for (int i = 0; i < 7; i++) send(0, 1'b1, 6'(i + 1));
    send(0, 1'b1, 6'h3F);
    opv_i[0] = 1'b0;
    count_running(0, "def_drain_len", 3);
    chk("def_done", 64'(done_w[0]), 64'd1);

    // Start in DONE clears counters and re-enters core reset.
    pulse_start(0);
    chk("restart_clear", 64'({crn[0], done_w[0], get_st(0), get_cc(0), get_ic(0)}), 64'({1'b0, 1'b0, 3'd1, 32'd0, 32'd0}) );
    wait_core_up(0, "restart_crst_len");
    start_i[0] = 1'b1;
    send(0, 1'b1, 6'h07);
    start_i[0] = 1'b0;
    chk("start_ignored", 64'({run_w[0], get_st(0), get_cc(0)}), 64'({1'b1, 3'd2, 32'd1}));
    send(0, 1'b1, 6'h08);
    send(0, 1'b1, 6'h3F);
    opv_i[0] = 1'b0;
    @(negedge clk);
    chk("pre_abort_drain", 64'(get_st(0)), 64'd3);
    // Reset during DRAIN clears everything at once.
    rst_n = 1'b0;
    #1;
    chk("abort_flags", 64'({crn[0], run_w[0], done_w[0], to_w[0], get_st(0)}), 64'd0);
    chk("abort_counts", {get_cc(0), get_ic(0)}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 64'({done_w[0], to_w[0]}), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
